// File: rtl/ltm_pkg.sv
// Shared types and default geometry for the LTM panel video receiver.
// Geometry defaults match the 800x480 LTM panel.
package ltm_pkg;

  localparam int LTM_H_ACTIVE = 800;
  localparam int LTM_V_ACTIVE = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    UNLOCKED,
    SYNCED,
    LOCKED
  } ltm_rx_state_t;

endpackage

// File: rtl/ltm_sync_edge.sv
// Two-flop sample of a panel control line with edge detect.
// act is the asserted level of the first flop; chg flags any transition.
module ltm_sync_edge #(
  parameter bit ACT_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic act,
  output logic chg
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= ACT_LOW;
      s2 <= ACT_LOW;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign act = s1 ^ ACT_LOW;
  assign chg = s1 ^ s2;

endmodule

// File: rtl/ltm_video_rx.sv
// LTM panel video receiver: recovers pixel x/y, frame boundaries,
// geometry lock and length errors from the R/G/B/DEN/HD/VD bus.
module ltm_video_rx
  import ltm_pkg::*;
#(
  parameter int H_ACTIVE     = LTM_H_ACTIVE,
  parameter int V_ACTIVE     = LTM_V_ACTIVE,
  parameter bit SYNC_ACT_LOW = 1'b1
) (
  input  logic        display_clk,
  input  logic        reset_n,
  input  logic [7:0]  ltm_r,
  input  logic [7:0]  ltm_g,
  input  logic [7:0]  ltm_b,
  input  logic        ltm_den,
  input  logic        ltm_hd,
  input  logic        ltm_vd,
  output logic        pix_valid,
  output logic [23:0] pix_rgb,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        locked,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic [15:0] frame_count
);

  localparam logic [10:0] X_END  = 11'(H_ACTIVE);
  localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_END  = 10'(V_ACTIVE);

  logic hd_act, hd_chg;
  logic vd_act, vd_chg;
  logic den_act, den_chg;

  ltm_sync_edge #(.ACT_LOW(SYNC_ACT_LOW)) u_hd (
    .clk   (display_clk),
    .rst_n (reset_n),
    .d     (ltm_hd),
    .act   (hd_act),
    .chg   (hd_chg)
  );

  ltm_sync_edge #(.ACT_LOW(SYNC_ACT_LOW)) u_vd (
    .clk   (display_clk),
    .rst_n (reset_n),
    .d     (ltm_vd),
    .act   (vd_act),
    .chg   (vd_chg)
  );

  ltm_sync_edge #(.ACT_LOW(1'b0)) u_den (
    .clk   (display_clk),
    .rst_n (reset_n),
    .d     (ltm_den),
    .act   (den_act),
    .chg   (den_chg)
  );

  rgb888_t rgb_s1;

  always_ff @(posedge display_clk or negedge reset_n) begin
    if (!reset_n) rgb_s1 <= '0;
    else          rgb_s1 <= {ltm_r, ltm_g, ltm_b};
  end

  ltm_rx_state_t state, state_n;

  logic [10:0] x, x_n;
  logic [9:0]  y, y_n, y_cl;
  logic        h_ovr, h_ovr_n;
  logic        v_ovr, v_ovr_n, v_ovr_cl;
  logic        bad, bad_n;
  logic [15:0] fc_n;

  logic hd_cut, vd_start, den_fall;
  logic line_end, sample, chk, eval;
  logic hlen_bad, vlen_bad, good;
  logic hlen_err, vlen_err, pv;

  always_comb begin
    hd_cut   = hd_act & hd_chg & den_act;
    vd_start = vd_act & vd_chg;
    den_fall = ~den_act & den_chg;
    // a line may close on the very cycle VD starts, never inside VD
    line_end = (den_fall | hd_cut) & (~vd_act | vd_start);
    sample   = den_act & ~vd_act & ~hd_cut;
    chk      = (state != UNLOCKED);
    eval     = vd_start & chk;

    hlen_bad = line_end & ((x != X_END) | h_ovr);

    y_cl     = y;
    v_ovr_cl = v_ovr;
    if (line_end) begin
      if (y == Y_END) v_ovr_cl = 1'b1;
      else            y_cl     = y + 10'd1;
    end

    vlen_bad = (y_cl != Y_END) | v_ovr_cl;
    good     = ~bad & ~hlen_bad & ~vlen_bad;
    hlen_err = chk & hlen_bad;
    vlen_err = eval & vlen_bad;

    pv = sample & chk & ~h_ovr & (x != X_END) & (y < Y_END);

    x_n     = x;
    h_ovr_n = h_ovr;
    if (sample) begin
      if (x == X_END) h_ovr_n = 1'b1;
      else            x_n     = x + 11'd1;
    end
    y_n     = y_cl;
    v_ovr_n = v_ovr_cl;
    if (line_end) begin
      x_n     = '0;
      h_ovr_n = 1'b0;
    end

    bad_n = bad | hlen_bad | (den_act & vd_act);
    if (vd_start) begin
      x_n     = '0;
      h_ovr_n = 1'b0;
      y_n     = '0;
      v_ovr_n = 1'b0;
      bad_n   = den_act;
    end

    fc_n = frame_count + 16'(eval);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      UNLOCKED: if (vd_start)    state_n = SYNCED;
      SYNCED:   if (eval & good) state_n = LOCKED;
      LOCKED: begin
        if (hlen_err | (eval & ~good)) state_n = SYNCED;
      end
      default: state_n = UNLOCKED;
    endcase
  end

  always_ff @(posedge display_clk or negedge reset_n) begin
    if (!reset_n) state <= UNLOCKED;
    else          state <= state_n;
  end

  always_ff @(posedge display_clk or negedge reset_n) begin
    if (!reset_n) begin
      x           <= '0;
      y           <= '0;
      h_ovr       <= 1'b0;
      v_ovr       <= 1'b0;
      bad         <= 1'b0;
      pix_valid   <= 1'b0;
      pix_rgb     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
      frame_count <= '0;
    end else begin
      x           <= x_n;
      y           <= y_n;
      h_ovr       <= h_ovr_n;
      v_ovr       <= v_ovr_n;
      bad         <= bad_n;
      pix_valid   <= pv;
      pix_sof     <= pv & (x == '0) & (y == '0);
      pix_eol     <= pv & (x == X_LAST);
      err_hlen    <= hlen_err;
      err_vlen    <= vlen_err;
      frame_count <= fc_n;
      if (pv) begin
        pix_rgb <= rgb_s1;
        pix_x   <= x;
        pix_y   <= y;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
